// File: rtl/out_port_fifo_pkg.sv
// Shared I/O constants for the CPU output path.
// CPU_WrapperV3 imports these as well, so both sides agree on the port width and the FIFO depth.
package out_port_fifo_pkg;

    localparam int IO_DATA_W      = 8;
    localparam int OUT_FIFO_DEPTH = 4;

endpackage

// File: rtl/out_port_fifo_mem.sv
// Storage array for the output-port FIFO.
// It has one synchronous write port, one combinational read port, and no reset.
module out_port_fifo_mem
    import out_port_fifo_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = OUT_FIFO_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// OUT-instruction port stage: a first-word fall-through FIFO with a valid/ready sink side.
// When the FIFO is empty, O_Port keeps showing the last byte that was sent.
module out_port_fifo
    import out_port_fifo_pkg::*;
#(
    parameter  int DATA_W = IO_DATA_W,
    parameter  int DEPTH  = OUT_FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic [DATA_W-1:0] O_Port,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [PTR_W:0]    level,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    level_q;
    logic [DATA_W-1:0] last_q;
    logic              overflow_q;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              pop;

    assign o_valid = (level_q != '0);
    assign full    = (level_q == LEVEL_FULL);
    assign pop     = o_valid && o_ready;
    // A pop on the same edge frees a slot, so a write into a full FIFO is still accepted.
    assign push    = wr_en && (!full || pop);

    assign level    = level_q;
    assign overflow = overflow_q;
    assign O_Port   = o_valid ? head_data : last_q;

    out_port_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= head_data;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
            // If a new overflow and a clear happen on the same edge, the new overflow is kept.
            if (wr_en && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo.
// It is checked against a queue-based model of the output port.
module tb_out_port_fifo;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [DW-1:0] O_Port;
    logic          o_valid;
    logic          o_ready;
    logic [2:0]    level;
    logic          overflow;
    logic          ovf_clr;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_last;
    logic          m_ovf;

    out_port_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .O_Port   (O_Port),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] exp_port;
        exp_port = (m_q.size() != 0) ? m_q[0] : m_last;
        check({tag, ".o_valid"},  32'(o_valid),  32'(m_q.size() != 0));
        check({tag, ".O_Port"},   32'(O_Port),   32'(exp_port));
        check({tag, ".level"},    32'(level),    32'(m_q.size()));
        check({tag, ".full"},     32'(full),     32'(m_q.size() == DP));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
    endtask

    // The model applies the pop, push and overflow rules to the state as it was before the edge.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
        logic m_pop;
        logic m_full;
        wr_en   = w;
        wr_data = d;
        o_ready = r;
        ovf_clr = c;
        m_full = (m_q.size() == DP);
        m_pop  = (m_q.size() != 0) && r;
        if (m_pop) begin
            m_last = m_q.pop_front();
        end
        if (w && (!m_full || m_pop)) begin
            m_q.push_back(d);
        end
        if (w && m_full && !m_pop) begin
            m_ovf = 1'b1;
        end else if (c) begin
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // The reset is applied between clock edges, so the check also covers the asynchronous clear.
    task automatic async_reset(input string tag);
        wr_en   = 1'b0;
        o_ready = 1'b0;
        ovf_clr = 1'b0;
        rst     = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] drain_exp [4];
        drain_exp[0] = 8'h22;
        drain_exp[1] = 8'h33;
        drain_exp[2] = 8'h44;
        drain_exp[3] = 8'h66;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        o_ready = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Test 1: first-word fall-through after a single push.
        step("t1_push", 1'b1, 8'h5A, 1'b0, 1'b0);
        check("t1_port_const", 32'(O_Port), 32'h5A);

        // Test 2: fill the FIFO, then push once more to cause an overflow.
        async_reset("t2_reset");
        step("t2_p11", 1'b1, 8'h11, 1'b0, 1'b0);
        step("t2_p22", 1'b1, 8'h22, 1'b0, 1'b0);
        step("t2_p33", 1'b1, 8'h33, 1'b0, 1'b0);
        step("t2_p44", 1'b1, 8'h44, 1'b0, 1'b0);
        check("t2_full_const", 32'(full), 32'h1);
        step("t2_ovf", 1'b1, 8'h55, 1'b0, 1'b0);
        check("t2_ovf_const", 32'(overflow), 32'h1);
        check("t2_head_const", 32'(O_Port), 32'h11);

        // Test 3: push and pop on the same cycle while full, then drain the FIFO.
        step("t3_pushpop", 1'b1, 8'h66, 1'b1, 1'b0);
        check("t3_level_const", 32'(level), 32'h4);
        for (int i = 0; i < 4; i++) begin
            check("t3_drain_head", 32'(O_Port), 32'(drain_exp[i]));
            step("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Test 4: the port stays latched when empty, and o_ready is ignored.
        step("t4_idle0", 1'b0, 8'h00, 1'b1, 1'b0);
        step("t4_idle1", 1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_hold_const", 32'(O_Port), 32'h66);

        // Clearing the overflow flag; when a set and a clear arrive on the same cycle, the set wins.
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DP; i++) begin
            step("ovf_fill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        end
        step("ovf_set_clr", 1'b1, 8'hEE, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'h1);
        step("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DP; i++) begin
            step("ovf_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Test 5: randomized streaming with a toggling o_ready, long enough to wrap the pointers.
        for (int i = 0; i < 60; i++) begin
            step("t5_rand", 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < DP + 1; i++) begin
            step("t5_flush", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Test 6: an asynchronous reset in mid-stream, then a push right after it.
        step("t6_p0", 1'b1, 8'h01, 1'b0, 1'b0);
        step("t6_p1", 1'b1, 8'h02, 1'b0, 1'b0);
        step("t6_p2", 1'b1, 8'h03, 1'b0, 1'b0);
        check("t6_level3", 32'(level), 32'h3);
        async_reset("t6_reset");
        check("t6_port_zero", 32'(O_Port), 32'h0);
        step("t6_push", 1'b1, 8'hA5, 1'b0, 1'b0);
        check("t6_port_const", 32'(O_Port), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
